// File: rtl/div_arbiter.sv
// div_arbiter: shares one combinational divide unit between two requesters.
//   Round-robin accept on req0/req1 valid/ready, operands held on div_in1/div_in2
//   for SETTLE cycles, then quotient/remainder captured and returned on the
//   granted requester's rsp valid/ready channel. Zero divisors bypass the divider.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   reqN_valid/ready/dividend/divisor  request channels (N = 0, 1)
//   rspN_valid/ready               response channels
//   rsp_quot, rsp_rem, rsp_dz      shared response payload
//   div_in1, div_in2 / div_a, div_b  divide unit operands / results
//   busy                           high whenever not IDLE
// Optional build macro DIV_STATS_EN adds op_count/dz_count saturating counters.
module div_arbiter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_quot,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_dz,
    output logic [WIDTH-1:0] div_in1,
    output logic [WIDTH-1:0] div_in2,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    output logic             busy
`ifdef DIV_STATS_EN
    ,
    output logic [15:0]      op_count,
    output logic [7:0]       dz_count
`endif
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last_grant;
    logic            any_valid_c;
    logic            grant_c;
    logic            accept_c;
    logic            rsp_hs_c;
    logic [WIDTH-1:0] sel_dvd_c;
    logic [WIDTH-1:0] sel_dvs_c;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        any_valid_c = req0_valid | req1_valid;
        grant_c     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant;
        end else if (req1_valid) begin
            grant_c = 1'b1;
        end
    end

    assign accept_c   = (state == IDLE) && any_valid_c;
    assign req0_ready = accept_c && !grant_c;
    assign req1_ready = accept_c && grant_c;
    assign sel_dvd_c  = grant_c ? req1_dividend : req0_dividend;
    assign sel_dvs_c  = grant_c ? req1_divisor  : req0_divisor;
    assign rsp_hs_c   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    // Controller: accept -> settle count -> capture -> hold response until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            div_in1    <= '0;
            div_in2    <= '0;
            rsp_quot   <= '0;
            rsp_rem    <= '0;
            rsp_dz     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        div_in1    <= sel_dvd_c;
                        div_in2    <= sel_dvs_c;
                        last_grant <= grant_c;
                        busy       <= 1'b1;
                        if (sel_dvs_c != '0) begin
                            state <= ISSUE;
                            cnt   <= CW'(SETTLE - 1);
                        end else begin
                            // Zero divisor resolved locally; divider output ignored.
                            state      <= RESP;
                            rsp_quot   <= '1;
                            rsp_rem    <= sel_dvd_c;
                            rsp_dz     <= 1'b1;
                            rsp0_valid <= !grant_c;
                            rsp1_valid <= grant_c;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        rsp_quot   <= div_a;
                        rsp_rem    <= div_b;
                        rsp_dz     <= 1'b0;
                        rsp0_valid <= !last_grant;
                        rsp1_valid <= last_grant;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_hs_c) begin
                        state      <= IDLE;
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIV_STATS_EN
    // Saturating operation and divide-by-zero counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
            dz_count <= '0;
        end else if (accept_c) begin
            if (op_count != '1) begin
                op_count <= op_count + 16'd1;
            end
            if ((sel_dvs_c == '0) && (dz_count != '1)) begin
                dz_count <= dz_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SETTLE = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend = '0;
    logic [WIDTH-1:0] req0_divisor = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend = '0;
    logic [WIDTH-1:0] req1_divisor = '0;
    logic             rsp0_valid;
    logic             rsp0_ready = 1'b1;
    logic             rsp1_valid;
    logic             rsp1_ready = 1'b1;
    logic [WIDTH-1:0] rsp_quot;
    logic [WIDTH-1:0] rsp_rem;
    logic             rsp_dz;
    logic [WIDTH-1:0] div_in1;
    logic [WIDTH-1:0] div_in2;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             busy;
`ifdef DIV_STATS_EN
    logic [15:0]      op_count;
    logic [7:0]       dz_count;
`endif

    always #5 clk = ~clk;

    // Divide unit: garbage on zero divisor so a consumed result would show.
    assign div_a = (div_in2 == '0) ? 16'hDEAD : div_in1 / div_in2;
    assign div_b = (div_in2 == '0) ? 16'hBEEF : div_in1 % div_in2;

    div_arbiter #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz),
        .div_in1(div_in1), .div_in2(div_in2),
        .div_a(div_a), .div_b(div_b),
        .busy(busy)
`ifdef DIV_STATS_EN
        , .op_count(op_count), .dz_count(dz_count)
`endif
    );

    typedef struct { logic [15:0] dvd; logic [15:0] dvs; } op_t;
    typedef struct { int who; logic [15:0] q; logic [15:0] r; logic dz; } rsp_t;

    op_t  q0[$];
    op_t  q1[$];
    rsp_t rsp_log[$];
    int   gseq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_rr = 1'b0;
    logic rr0 = 1'b1;
    logic rr1 = 1'b1;

    // Transaction-level reference: one outstanding op, its owner, due cycle and result.
    bit          outst = 1'b0;
    int          og = 0;
    int          ocyc = 0;
    logic [15:0] odvd = '0;
    logic [15:0] odvs = '0;
    logic [15:0] oq = '0;
    logic [15:0] orm = '0;
    logic        odz = 1'b0;
    int          last = 1;
    int          op_m = 0;
    int          dz_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_reset();
        chk("rst_div_in1", 32'(div_in1), 32'h0);
        chk("rst_div_in2", 32'(div_in2), 32'h0);
        chk("rst_quot", 32'(rsp_quot), 32'h0);
        chk("rst_rem", 32'(rsp_rem), 32'h0);
        chk("rst_dz", 32'(rsp_dz), 32'h0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
    endtask

    // One clock: drive from the queues, compare against the reference, advance it.
    task automatic cycle_chk();
        int   g;
        bit   ev0;
        bit   ev1;
        bit   in_rst;
        op_t  op;
        rsp_t r;
        req0_valid = (q0.size() != 0);
        if (req0_valid) begin
            req0_dividend = q0[0].dvd;
            req0_divisor  = q0[0].dvs;
        end
        req1_valid = (q1.size() != 0);
        if (req1_valid) begin
            req1_dividend = q1[0].dvd;
            req1_divisor  = q1[0].dvs;
        end
        if (rand_rr) begin
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
        end else begin
            rsp0_ready = rr0;
            rsp1_ready = rr1;
        end
        #1;
        in_rst = !rst_n;
        if (!in_rst) begin
            g = -1;
            if (!outst) begin
                if (req0_valid && req1_valid) g = (last == 1) ? 0 : 1;
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
            end
            chk("req0_ready", 32'(req0_ready), 32'(g == 0));
            chk("req1_ready", 32'(req1_ready), 32'(g == 1));
            chk("busy", 32'(busy), 32'(outst));
            ev0 = outst && (og == 0) && (cyc >= ocyc);
            ev1 = outst && (og == 1) && (cyc >= ocyc);
            chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
            if (outst) begin
                chk("div_in1", 32'(div_in1), 32'(odvd));
                chk("div_in2", 32'(div_in2), 32'(odvs));
            end
            if (ev0 || ev1) begin
                chk("rsp_quot", 32'(rsp_quot), 32'(oq));
                chk("rsp_rem", 32'(rsp_rem), 32'(orm));
                chk("rsp_dz", 32'(rsp_dz), 32'(odz));
            end
`ifdef DIV_STATS_EN
            chk("op_count", 32'(op_count), 32'(op_m));
            chk("dz_count", 32'(dz_count), 32'(dz_m));
`endif
            if (g >= 0) begin
                op = (g == 1) ? q1.pop_front() : q0.pop_front();
                last  = g;
                outst = 1'b1;
                og    = g;
                odvd  = op.dvd;
                odvs  = op.dvs;
                odz   = (op.dvs == 16'd0);
                oq    = odz ? 16'hFFFF : op.dvd / op.dvs;
                orm   = odz ? op.dvd : op.dvd % op.dvs;
                ocyc  = cyc + (odz ? 1 : int'(SETTLE) + 1);
                gseq.push_back(g);
                if (op_m < 65535) op_m++;
                if (odz && dz_m < 255) dz_m++;
            end else if ((ev0 && rsp0_ready) || (ev1 && rsp1_ready)) begin
                r.who = og; r.q = oq; r.r = orm; r.dz = odz;
                rsp_log.push_back(r);
                outst = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (in_rst) begin
            outst = 1'b0;
            last  = 1;
            op_m  = 0;
            dz_m  = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_chk();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        run(n);
        rst_n = 1'b1;
        chk_reset();
    endtask

    task automatic push(input int who, input logic [15:0] dvd, input logic [15:0] dvs);
        op_t op;
        op.dvd = dvd;
        op.dvs = dvs;
        if (who == 0) q0.push_back(op);
        else          q1.push_back(op);
    endtask

    task automatic chk_log(input string tag, input int idx, input int who,
                           input logic [15:0] q, input logic [15:0] r, input logic dz);
        chk({tag, "_count"}, 32'(rsp_log.size() > idx), 32'h1);
        if (rsp_log.size() > idx) begin
            chk({tag, "_who"}, 32'(rsp_log[idx].who), 32'(who));
            chk({tag, "_quot"}, 32'(rsp_log[idx].q), 32'(q));
            chk({tag, "_rem"}, 32'(rsp_log[idx].r), 32'(r));
            chk({tag, "_dz"}, 32'(rsp_log[idx].dz), 32'(dz));
        end
    endtask

    initial begin
        int base;
        int gbase;

        // Reset state
        do_reset(2);

        // Single op 100/7 on requester 0
        push(0, 16'd100, 16'd7);
        run(8);
        chk_log("single", 0, 0, 16'd14, 16'd2, 1'b0);

        // Divide by zero on requester 1
        push(1, 16'd55, 16'd0);
        run(5);
        chk_log("divzero", 1, 1, 16'hFFFF, 16'd55, 1'b1);

        // Contention from reset: ties alternate starting with requester 0
        do_reset(1);
        base  = rsp_log.size();
        gbase = gseq.size();
        push(0, 16'd8, 16'd3);  push(0, 16'd20, 16'd4);
        push(1, 16'd15, 16'd7); push(1, 16'd9, 16'd0);
        run(20);
        chk("grant_cnt", 32'(gseq.size() - gbase), 32'd4);
        if (gseq.size() - gbase >= 4) begin
            chk("grant0", 32'(gseq[gbase]), 32'd0);
            chk("grant1", 32'(gseq[gbase + 1]), 32'd1);
            chk("grant2", 32'(gseq[gbase + 2]), 32'd0);
            chk("grant3", 32'(gseq[gbase + 3]), 32'd1);
        end
        chk_log("cont_a", base, 0, 16'd2, 16'd2, 1'b0);
        chk_log("cont_b", base + 1, 1, 16'd2, 16'd1, 1'b0);

        // Response backpressure on requester 0 while requester 1 waits
        base = rsp_log.size();
        rr0 = 1'b0;
        push(0, 16'd1000, 16'd10);
        push(1, 16'd77, 16'd7);
        run(9);
        rr0 = 1'b1;
        run(10);
        chk_log("bp_a", base, 0, 16'd100, 16'd0, 1'b0);
        chk_log("bp_b", base + 1, 1, 16'd11, 16'd0, 1'b0);

        // Reset in the first ISSUE cycle; lost op yields no response
        base  = rsp_log.size();
        gbase = gseq.size();
        push(0, 16'd500, 16'd3);
        for (int i = 0; i < 10 && gseq.size() == gbase; i++) cycle_chk();
        chk("midop_accept", 32'(gseq.size()), 32'(gbase + 1));
        do_reset(1);
        chk("midop_no_rsp", 32'(rsp_log.size()), 32'(base));
        gbase = gseq.size();
        push(0, 16'd9, 16'd2);
        push(1, 16'd9, 16'd4);
        run(14);
        chk("midop_tie", 32'(gseq.size() > gbase), 32'h1);
        if (gseq.size() > gbase) chk("midop_tie_winner", 32'(gseq[gbase]), 32'd0);
        chk_log("midop_a", base, 0, 16'd4, 16'd1, 1'b0);

        // Randomized traffic with random response backpressure
        rand_rr = 1'b1;
        for (int i = 0; i < 600; i++) begin
            for (int w = 0; w < 2; w++) begin
                if ((w == 0 ? q0.size() : q1.size()) < 2 && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 4) == 0)      push(w, 16'($urandom), 16'd0);
                    else if ($urandom_range(0, 1) == 0) push(w, 16'($urandom), 16'($urandom_range(1, 20)));
                    else                                push(w, 16'($urandom), 16'($urandom_range(1, 65535)));
                end
            end
            cycle_chk();
        end
        rand_rr = 1'b0;
        rr0 = 1'b1;
        rr1 = 1'b1;
        for (int i = 0; i < 40 && (outst || q0.size() != 0 || q1.size() != 0); i++) cycle_chk();
        chk("drain_idle", 32'(outst || q0.size() != 0 || q1.size() != 0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
